// File: rtl/ram_dp_sync_pkg.sv
// Shared definitions for the ram_dp_sync RAM slice: read-during-write policy codes,
// sequencer state encoding and byte-lane width.
package ram_dp_sync_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RAM_LANE_W      = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ram_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer for ram_dp_sync: sweeps every address once with a zero
// write strobe, then holds RUN; busy covers reset and the sweep.
module ram_clear_seq
    import ram_dp_sync_pkg::*;
#(
    parameter int A              = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         busy,
    output logic [A-1:0] clr_addr,
    output logic         clr_we
);

    localparam logic [A-1:0] CNT_LAST = {A{1'b1}};
    localparam logic [A-1:0] CNT_ONE  = {{(A-1){1'b0}}, 1'b1};
    localparam ram_state_t   ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    ram_state_t   state_r;
    logic [A-1:0] cnt_r;
    logic         busy_r;

    // State, sweep counter and busy flag; busy drops on the edge that writes the last word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RESET;
            cnt_r   <= {A{1'b0}};
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                    cnt_r   <= cnt_r;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_RESET;
                    cnt_r   <= {A{1'b0}};
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign clr_addr = cnt_r;
    assign clr_we   = (state_r == ST_CLEAR);

endmodule

// File: rtl/ram_dp_sync.sv
// Simple-dual-port synchronous RAM: port A read/write with byte lanes, port B read-only.
// Define RAM_DP_SYNC_OUTREG_EN to add an output register stage (2-cycle read latency).
module ram_dp_sync
    import ram_dp_sync_pkg::*;
#(
    parameter int A              = 10,
    parameter int D              = 8,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [A-1:0]          a_addr,
    input  logic [D-1:0]          a_din,
    input  logic [D/RAM_LANE_W-1:0] a_we,
    input  logic                  a_re,
    output logic [D-1:0]          a_dout,
    output logic                  a_valid,
    input  logic [A-1:0]          b_addr,
    input  logic                  b_re,
    output logic [D-1:0]          b_dout,
    output logic                  b_valid,
    output logic                  busy
);

    localparam int L     = D / RAM_LANE_W;
    localparam int DEPTH = 1 << A;

    logic [D-1:0] mem_r [DEPTH];

    logic         busy_s;
    logic         clr_we_s;
    logic [A-1:0] clr_addr_s;
    logic         run_s;
    logic         any_we_s;
    logic         b_hit_s;
    logic [D-1:0] a_old_s;
    logic [D-1:0] b_old_s;
    logic [D-1:0] a_merged_s;
    logic [D-1:0] a_next_s;
    logic [D-1:0] b_next_s;

    logic [D-1:0] a_dout_r;
    logic         a_valid_r;
    logic [D-1:0] b_dout_r;
    logic         b_valid_r;

    function automatic logic [D-1:0] lane_merge(input logic [D-1:0] old_w,
                                                input logic [D-1:0] new_w,
                                                input logic [L-1:0] we);
        logic [D-1:0] res;
        res = old_w;
        for (int i = 0; i < L; i++) begin
            if (we[i]) begin
                res[i*RAM_LANE_W +: RAM_LANE_W] = new_w[i*RAM_LANE_W +: RAM_LANE_W];
            end else begin
                res[i*RAM_LANE_W +: RAM_LANE_W] = old_w[i*RAM_LANE_W +: RAM_LANE_W];
            end
        end
        return res;
    endfunction

    ram_clear_seq #(
        .A              (A),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy_s),
        .clr_addr (clr_addr_s),
        .clr_we   (clr_we_s)
    );

    assign run_s      = ~busy_s;
    assign any_we_s   = (a_we != {L{1'b0}});
    assign a_old_s    = mem_r[a_addr];
    assign b_old_s    = mem_r[b_addr];
    assign a_merged_s = lane_merge(a_old_s, a_din, a_we);
    assign b_hit_s    = (a_addr == b_addr) && any_we_s;
    // Unwritten lanes of the merged word are the old data, so write-first needs no extra case.
    assign a_next_s   = (RDW_MODE == RDW_READ_FIRST) ? a_old_s : a_merged_s;
    assign b_next_s   = ((RDW_MODE == RDW_WRITE_FIRST) && b_hit_s) ? a_merged_s : b_old_s;

    // Array write path: clear sweep has priority, user writes only once running.
    always_ff @(posedge clk) begin
        if (rst_n && clr_we_s) begin
            mem_r[clr_addr_s] <= {D{1'b0}};
        end else if (rst_n && run_s && any_we_s) begin
            mem_r[a_addr] <= a_merged_s;
        end
    end

    // Port A read register; dout holds while idle, valid pulses per accepted request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_dout_r  <= {D{1'b0}};
            a_valid_r <= 1'b0;
        end else if (run_s && a_re) begin
            a_dout_r  <= a_next_s;
            a_valid_r <= 1'b1;
        end else begin
            a_dout_r  <= a_dout_r;
            a_valid_r <= 1'b0;
        end
    end

    // Port B read register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_dout_r  <= {D{1'b0}};
            b_valid_r <= 1'b0;
        end else if (run_s && b_re) begin
            b_dout_r  <= b_next_s;
            b_valid_r <= 1'b1;
        end else begin
            b_dout_r  <= b_dout_r;
            b_valid_r <= 1'b0;
        end
    end

`ifdef RAM_DP_SYNC_OUTREG_EN
    logic [D-1:0] a_dout_q_r;
    logic         a_valid_q_r;
    logic [D-1:0] b_dout_q_r;
    logic         b_valid_q_r;

    // Extra output stage; it only delays, the read-during-write result is already settled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_dout_q_r  <= {D{1'b0}};
            a_valid_q_r <= 1'b0;
            b_dout_q_r  <= {D{1'b0}};
            b_valid_q_r <= 1'b0;
        end else begin
            a_dout_q_r  <= a_dout_r;
            a_valid_q_r <= a_valid_r;
            b_dout_q_r  <= b_dout_r;
            b_valid_q_r <= b_valid_r;
        end
    end

    assign a_dout  = a_dout_q_r;
    assign a_valid = a_valid_q_r;
    assign b_dout  = b_dout_q_r;
    assign b_valid = b_valid_q_r;
`else
    assign a_dout  = a_dout_r;
    assign a_valid = a_valid_r;
    assign b_dout  = b_dout_r;
    assign b_valid = b_valid_r;
`endif

    assign busy = busy_s;

endmodule
